// File: rtl/uart_io_pkg.sv
// Shared IO constants for the UART receive register block.
// Status word bit positions and register addresses.
package uart_io_pkg;

   localparam int OVR_BIT    = 15;
   localparam int FULL_BIT   = 14;
   localparam int NEMPTY_BIT = 13;
   localparam int COUNT_LSB  = 8;
   localparam int COUNT_W    = 5;

   localparam logic [7:0] UART_RX_DATA_ADDR = 8'h00;
   localparam logic [7:0] UART_RX_STAT_ADDR = 8'h04;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Byte storage for the UART receive FIFO.
// Synchronous write port, asynchronous read port, no reset.
module fifo_ram #(
   parameter int AW = 4
) (
   input  logic          clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [2**AW];

   // write the incoming byte at the write pointer
   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with sticky overrun and IO status word.
// Define UART_RX_FIFO_IRQ_EN to enable the registered irq output.
module uart_rx_fifo
   import uart_io_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int IRQ_LEVEL  = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        pop,
   input  logic        clear_overrun,
   output logic [15:0] status_out,
   output logic        irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_ovr;
   logic                  r_ready;

   logic        w_full;
   logic        w_empty;
   logic        w_in;
   logic        w_push;
   logic        w_pop;
   logic        w_ovr_set;
   logic [7:0]  w_head;
   logic [15:0] w_status;

   assign w_full    = (r_count == LP_DEPTH);
   assign w_empty   = (r_count == '0);
   assign w_in      = s_axis_tvalid & r_ready;
   assign w_pop     = pop & ~w_empty;
   // at full a same-cycle pop frees the slot being written
   assign w_push    = w_in & (~w_full | pop);
   assign w_ovr_set = w_in & w_full & ~pop;

   fifo_ram #(
      .AW (DEPTH_LOG2)
   ) u_ram (
      .clock   (clock),
      .i_we    (w_push),
      .i_waddr (r_wptr),
      .i_wdata (s_axis_tdata),
      .i_raddr (r_rptr),
      .o_rdata (w_head)
   );

   // ready is registered so it stays low while reset is held
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_ready <= 1'b0;
      else          r_ready <= 1'b1;
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   // sticky overrun; a new overrun beats a clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)           r_ovr <= 1'b0;
      else if (w_ovr_set)     r_ovr <= 1'b1;
      else if (clear_overrun) r_ovr <= 1'b0;
   end

   // status word assembled from registered state only
   always_comb begin
      w_status = '0;
      w_status[OVR_BIT]    = r_ovr;
      w_status[FULL_BIT]   = w_full;
      w_status[NEMPTY_BIT] = ~w_empty;
      w_status[COUNT_LSB +: COUNT_W] = COUNT_W'(r_count);
      w_status[7:0] = w_empty ? 8'h00 : w_head;
   end

   assign status_out    = w_status;
   assign s_axis_tready = r_ready;

`ifdef UART_RX_FIFO_IRQ_EN
   localparam logic [CW-1:0] LP_IRQ_LEVEL = CW'(IRQ_LEVEL);

   logic r_irq;

   // irq follows the level/overrun condition one edge later
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_irq <= 1'b0;
      else          r_irq <= (r_count >= LP_IRQ_LEVEL) | r_ovr;
   end

   assign irq = r_irq;
`else
   logic w_unused_irq_level;

   assign w_unused_irq_level = ^IRQ_LEVEL;
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue model.
// Expects irq activity only when UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;

   localparam int DEPTH     = 16;
   localparam int IRQ_LEVEL = 1;

   logic        clock;
   logic        reset_n;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        pop;
   logic        clear_overrun;
   logic [15:0] status_out;
   logic        irq;

   int n_chk;
   int n_fail;

   logic [7:0] m_q [$];
   bit         m_ovr;
   bit         m_irq;
   bit         m_ready;

   uart_rx_fifo #(
      .DEPTH_LOG2 (4),
      .IRQ_LEVEL  (IRQ_LEVEL)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .pop           (pop),
      .clear_overrun (clear_overrun),
      .status_out    (status_out),
      .irq           (irq)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [15:0] exp_status();
      int n;
      logic [15:0] s;
      n = m_q.size();
      s = '0;
      s[15] = m_ovr;
      s[14] = (n == DEPTH);
      s[13] = (n != 0);
      s[12:8] = 5'(n);
      s[7:0] = (n != 0) ? m_q[0] : 8'h00;
      return s;
   endfunction

   function automatic logic exp_irq();
`ifdef UART_RX_FIFO_IRQ_EN
      return m_irq;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ovr   = 0;
      m_irq   = 0;
      m_ready = 0;
   endtask

   task automatic model_step(input bit tv, input logic [7:0] d,
                             input bit p, input bit c);
      int n;
      bit acc, ovr_set, irq_nx;
      n = m_q.size();
      irq_nx = (n >= IRQ_LEVEL) || m_ovr;
      acc = tv && m_ready;
      ovr_set = acc && (n == DEPTH) && !p;
      if (p && n > 0) void'(m_q.pop_front());
      if (acc && !ovr_set) m_q.push_back(d);
      if (ovr_set) m_ovr = 1;
      else if (c)  m_ovr = 0;
      m_irq   = irq_nx;
      m_ready = 1;
   endtask

   // one clock: inputs held across the edge, results sampled on negedge
   task automatic tick(input bit tv, input logic [7:0] d,
                       input bit p, input bit c);
      s_axis_tvalid = tv;
      s_axis_tdata  = d;
      pop           = p;
      clear_overrun = c;
      @(posedge clock);
      model_step(tv, d, p, c);
      @(negedge clock);
      s_axis_tvalid = 0;
      s_axis_tdata  = 8'h00;
      pop           = 0;
      clear_overrun = 0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      #2 reset_n = 0;
      model_reset();
      #1;
      n_chk++;
      if (status_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_status got=%h exp=0000", status_out);
      end
      n_chk++;
      if (s_axis_tready !== 1'b0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs got tready=%b irq=%b exp 0/0",
                  s_axis_tready, irq);
      end
      @(negedge clock);
      @(negedge clock);
      reset_n = 1;
      tick(0, 8'h00, 0, 0);
      n_chk++;
      if (s_axis_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset got=%b exp=1", s_axis_tready);
      end
      n_chk++;
      if (status_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL idle_status got=%h exp=0000", status_out);
      end
   endtask

   task automatic test_single_push();
      tick(1, 8'h41, 0, 0);
      n_chk++;
      if (status_out !== 16'h2141 || status_out !== exp_status()) begin
         n_fail++;
         $display("FAIL single_status got=%h exp=2141", status_out);
      end
      n_chk++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL single_irq_early got=%b exp=0", irq);
      end
      tick(0, 8'h00, 0, 0);
      n_chk++;
      if (irq !== exp_irq()) begin
         n_fail++;
         $display("FAIL single_irq got=%b exp=%b", irq, exp_irq());
      end
      tick(0, 8'h00, 1, 0);
      n_chk++;
      if (status_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL single_pop got=%h exp=0000", status_out);
      end
   endtask

   task automatic test_pop_empty();
      for (int i = 0; i < 3; i++) begin
         tick(0, 8'h00, 1, 0);
         n_chk++;
         if (status_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL pop_empty[%0d] got=%h exp=0000", i, status_out);
         end
      end
      tick(1, 8'h7E, 0, 0);
      n_chk++;
      if (status_out !== 16'h217E) begin
         n_fail++;
         $display("FAIL push_after_empty_pop got=%h exp=217e", status_out);
      end
      tick(0, 8'h00, 1, 0);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) tick(1, 8'(i), 0, 0);
      n_chk++;
      if (status_out !== 16'h7000) begin
         n_fail++;
         $display("FAIL full_status got=%h exp=7000", status_out);
      end
      tick(1, 8'hAA, 0, 0);
      n_chk++;
      if (status_out !== 16'hF000 || status_out !== exp_status()) begin
         n_fail++;
         $display("FAIL overrun_status got=%h exp=f000", status_out);
      end
   endtask

   task automatic test_clear_overrun();
      tick(1, 8'hBB, 0, 1);
      n_chk++;
      if (status_out[15] !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_set_priority got=%b exp=1", status_out[15]);
      end
      tick(0, 8'h00, 0, 1);
      n_chk++;
      if (status_out !== 16'h7000) begin
         n_fail++;
         $display("FAIL ovr_clear got=%h exp=7000", status_out);
      end
   endtask

   task automatic test_full_push_pop();
      tick(1, 8'h55, 1, 0);
      n_chk++;
      if (status_out !== 16'h7001) begin
         n_fail++;
         $display("FAIL full_push_pop got=%h exp=7001", status_out);
      end
      for (int i = 0; i < 15; i++) tick(0, 8'h00, 1, 0);
      n_chk++;
      if (status_out !== 16'h2155 || status_out !== exp_status()) begin
         n_fail++;
         $display("FAIL head_after_wrap got=%h exp=2155", status_out);
      end
      tick(0, 8'h00, 1, 0);
      n_chk++;
      if (status_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL drain got=%h exp=0000", status_out);
      end
   endtask

   task automatic test_random();
      bit tv, p, c;
      logic [7:0] d;
      for (int i = 0; i < 400; i++) begin
         tv = ($urandom_range(0, 99) < 60);
         p  = ($urandom_range(0, 99) < 40);
         c  = ($urandom_range(0, 99) < 10);
         d  = 8'($urandom);
         tick(tv, d, p, c);
         n_chk++;
         if (status_out !== exp_status()) begin
            n_fail++;
            $display("FAIL rand_status[%0d] got=%h exp=%h",
                     i, status_out, exp_status());
         end
         n_chk++;
         if (irq !== exp_irq() || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_outs[%0d] got irq=%b rdy=%b exp irq=%b rdy=1",
                     i, irq, s_axis_tready, exp_irq());
         end
      end
      while (m_q.size() > 0) tick(0, 8'h00, 1, 1);
      tick(0, 8'h00, 0, 1);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) tick(1, 8'(8'h30 + i), 0, 0);
      n_chk++;
      if (status_out !== 16'h2530) begin
         n_fail++;
         $display("FAIL five_stored got=%h exp=2530", status_out);
      end
      s_axis_tvalid = 1;
      s_axis_tdata  = 8'hEE;
      #2 reset_n = 0;
      model_reset();
      #1;
      n_chk++;
      if (status_out !== 16'h0000 || s_axis_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got status=%h rdy=%b exp 0000/0",
                  status_out, s_axis_tready);
      end
      @(negedge clock);
      s_axis_tvalid = 0;
      #2 reset_n = 1;
      @(negedge clock);
      tick(0, 8'h00, 0, 0);
      n_chk++;
      if (status_out !== 16'h0000 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset got status=%h irq=%b exp 0000/0",
                  status_out, irq);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset_n       = 0;
      s_axis_tvalid = 0;
      s_axis_tdata  = 8'h00;
      pop           = 0;
      clear_overrun = 0;
      model_reset();
      test_reset();
      test_single_push();
      test_pop_empty();
      test_overflow();
      test_clear_overrun();
      test_full_push_pop();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of FIFO depth; legal range 2..4.
REQ-002 SHALL have parameter IRQ_LEVEL, default 1, meaning the occupancy at which irq asserts; legal range 1..2**DEPTH_LOG2.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port s_axis_tdata, input, 8, the received byte from the UART receiver.
REQ-006 SHALL have port s_axis_tvalid, input, 1, meaning the received byte is valid.
REQ-007 SHALL have port s_axis_tready, output, 1, the FIFO accept indication.
REQ-008 SHALL have port pop, input, 1, a one-cycle strobe from the IO decoder that removes the head byte.
REQ-009 SHALL have port clear_overrun, input, 1, a one-cycle strobe that clears the sticky overrun flag.
REQ-010 SHALL have port status_out, output, 16, the IO-readable status word.
REQ-011 SHALL have port irq, output, 1, the receive interrupt request.

Function
REQ-012 SHALL drive s_axis_tready to 1 in every cycle out of reset, independent of occupancy; there is no combinational path from pop to s_axis_tready.
REQ-013 SHALL push on s_axis_tvalid and s_axis_tready when not full, or when full with pop in the same cycle.
REQ-014 SHALL drop the byte and set overrun when s_axis_tvalid is high, the FIFO is full and pop is low; FIFO contents SHALL be unchanged.
REQ-015 SHALL remove the head byte on pop when count>0; a pop when empty SHALL be ignored and cause no flag change.
REQ-016 SHALL leave count unchanged and advance both pointers on a simultaneous push and pop, including at full; at empty, push-only applies.
REQ-017 SHALL use read/write pointers of DEPTH_LOG2 bits that wrap modulo depth, and a count of DEPTH_LOG2+1 bits ranging 0..depth.
REQ-018 SHALL give set priority over clear when a new overrun and clear_overrun coincide.
REQ-019 SHALL form status_out combinationally from registered state: [15]=overrun, [14]=full, [13]=not empty, [12:8]=count zero-extended, [7:0]=head byte, or 0 when empty.
REQ-020 SHALL make a byte pushed at edge N visible in status_out after edge N, and a pop at edge N take effect after edge N.

Reset
REQ-021 SHALL, on reset_n low, immediately clear pointers, count and overrun, and force s_axis_tready=0, irq=0 and status_out=16'h0000.
REQ-022 SHALL discard any in-flight byte when reset is asserted mid-transfer; array contents need not be cleared.

Configuration
REQ-023 SHALL, with UART_RX_FIFO_IRQ_EN defined, register irq as (count>=IRQ_LEVEL) OR overrun, updated one edge after the condition changes.
REQ-024 SHALL, without UART_RX_FIFO_IRQ_EN, tie irq to constant 0 and leave IRQ_LEVEL unused; all other behaviour SHALL be identical.

Structure
REQ-025 SHALL take status bit positions (OVR_BIT=15, FULL_BIT=14, NEMPTY_BIT=13, COUNT_LSB=8) and the IO address constants for the UART RX register from shared package uart_io_pkg.
REQ-026 SHALL place storage in one sub-module, fifo_ram: a 2**DEPTH_LOG2 x 8 array with synchronous write and asynchronous read; control logic stays in uart_rx_fifo.

Verification
REQ-027 SHALL cover reset then push 8'h41 -> status_out=16'h2141 one cycle later, and irq=1 one further cycle later with IRQ_LEVEL=1 and the macro on.
REQ-028 SHALL cover pushing 16 bytes 8'h00..8'h0F, then one more byte 8'hAA without pop -> status_out=16'hF000, with 8'hAA absent.
REQ-029 SHALL cover, at full, a simultaneous push of 8'h55 and pop -> count stays 16, head becomes 8'h01, and after 15 further pops the head is 8'h55.
REQ-030 SHALL cover pop on empty -> status_out stays 16'h0000, and count does not underflow.
REQ-031 SHALL cover clear_overrun in the same cycle as a new overrun -> bit 15 stays 1, and a clear alone on the next cycle -> bit 15 becomes 0.
REQ-032 SHALL cover reset_n asserted asynchronously with 5 bytes stored -> status_out=16'h0000 and s_axis_tready=0 before the next clock edge.
